// File: rtl/addsub_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// addsub_rr_arbiter_pkg
//   Shared constants and types for the add/sub round-robin arbiter slice.
//   - state_t  : arbiter FSM states (IDLE, EXEC, RESP)
//   - MODE_*   : operation select encoding for the shared adder_subtractor
//   - ADDSUB_W : operand / result width
//   - ovf_flag : two's-complement overflow helper, used only when the
//                ADDSUB_OVF_FLAG_EN build option is enabled
// ---------------------------------------------------------------------------
package addsub_rr_arbiter_pkg;

    localparam int ADDSUB_W = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Overflow when both effective operands share a sign and the result
    // sign differs from it; for subtraction the B sign is inverted.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb,
                                      input logic mode, input logic s_msb);
        return (a_msb == (b_msb ^ mode)) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_subtractor.sv
// ---------------------------------------------------------------------------
// adder_subtractor
//   Combinational ADDSUB_W-bit adder/subtractor.
//   Ports:
//     a, b  in  operands
//     mode  in  MODE_ADD: s = a + b, MODE_SUB: s = a + ~b + 1
//     s     out result modulo 2**ADDSUB_W
//     cout  out carry-out (for subtraction 1 = no borrow)
// ---------------------------------------------------------------------------
module adder_subtractor
    import addsub_rr_arbiter_pkg::*;
(
    input  logic [ADDSUB_W-1:0] a,
    input  logic [ADDSUB_W-1:0] b,
    input  logic                mode,
    output logic [ADDSUB_W-1:0] s,
    output logic                cout
);

    logic [ADDSUB_W-1:0] b_eff;

    // Subtraction reuses the adder: invert B and inject mode as carry-in.
    assign b_eff     = b ^ {ADDSUB_W{mode}};
    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{ADDSUB_W{1'b0}}, mode};

endmodule

// File: rtl/addsub_rr_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_rr_arbiter
//   Shares one adder_subtractor between two requesters with round-robin
//   arbitration. IDLE grants one request, EXEC evaluates the shared unit
//   from latched operands, RESP holds the registered result until the
//   granted requester takes it. Accept in cycle T -> response valid in T+2.
//
//   Parameters:
//     INIT_PRIO  requester (0/1) that wins the first tie after reset
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     reqN_valid/ready         request handshake (ready combinational, IDLE only)
//     reqN_a, reqN_b, reqN_mode  operands and operation (0 = add, 1 = sub)
//     rspN_valid/ready         response handshake, only granted N goes valid
//     rsp_s, rsp_cout          registered result shared by both channels
//     rsp_ovf                  registered signed overflow
//                              (present only with `define ADDSUB_OVF_FLAG_EN)
// ---------------------------------------------------------------------------
module addsub_rr_arbiter
    import addsub_rr_arbiter_pkg::*;
#(
    parameter int INIT_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ADDSUB_W-1:0] req0_a,
    input  logic [ADDSUB_W-1:0] req0_b,
    input  logic                req0_mode,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ADDSUB_W-1:0] req1_a,
    input  logic [ADDSUB_W-1:0] req1_b,
    input  logic                req1_mode,

    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [ADDSUB_W-1:0] rsp_s,
    output logic                rsp_cout
`ifdef ADDSUB_OVF_FLAG_EN
    ,
    output logic                rsp_ovf
`endif
);

    state_t              state;
    logic                ptr;       // requester that wins the next tie
    logic [ADDSUB_W-1:0] op_a;
    logic [ADDSUB_W-1:0] op_b;
    logic                op_mode;
    logic                op_idx;    // granted requester of the in-flight op

    logic [ADDSUB_W-1:0] unit_s;
    logic                unit_cout;
    logic                rsp_done;

    adder_subtractor u_addsub (
        .a    (op_a),
        .b    (op_b),
        .mode (op_mode),
        .s    (unit_s),
        .cout (unit_cout)
    );

    // Grant select. Ready is held low during reset so nothing looks
    // accepted in a cycle whose state update is discarded.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state == ST_IDLE) begin
            if (req0_valid && (!req1_valid || ptr == 1'b0)) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    // Only the granted channel is ever valid, so the other ready is ignored.
    assign rsp_done = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= INIT_PRIO[0];
            // NOTE: operand registers are reset too, so the shared unit never evaluates X after reset.
            op_a       <= '0;
            op_b       <= '0;
            op_mode    <= MODE_ADD;
            op_idx     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_s      <= '0;
            rsp_cout   <= 1'b0;
`ifdef ADDSUB_OVF_FLAG_EN
            rsp_ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_a    <= req1_ready ? req1_a    : req0_a;
                        op_b    <= req1_ready ? req1_b    : req0_b;
                        op_mode <= req1_ready ? req1_mode : req0_mode;
                        op_idx  <= req1_ready;
                        ptr     <= ~req1_ready;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_s      <= unit_s;
                    rsp_cout   <= unit_cout;
`ifdef ADDSUB_OVF_FLAG_EN
                    rsp_ovf    <= ovf_flag(op_a[ADDSUB_W-1], op_b[ADDSUB_W-1],
                                           op_mode, unit_s[ADDSUB_W-1]);
`endif
                    rsp0_valid <= ~op_idx;
                    rsp1_valid <= op_idx;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    // Result registers keep their value after the handshake.
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_rr_arbiter
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a transaction-level reference model (in-flight op, accept cycle,
//   tie-break owner, last registered result computed with integer math).
// ---------------------------------------------------------------------------
module tb_addsub_rr_arbiter;

    localparam int INIT_PRIO = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_mode;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_mode;
    logic [3:0] req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [3:0] rsp_s;
    logic       rsp_cout;
`ifdef ADDSUB_OVF_FLAG_EN
    logic       rsp_ovf;
`endif

    always #5 clk = ~clk;

    addsub_rr_arbiter #(.INIT_PRIO(INIT_PRIO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_mode  (req1_mode),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_s      (rsp_s),
        .rsp_cout   (rsp_cout)
`ifdef ADDSUB_OVF_FLAG_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state.
    int         cyc     = 0;
    bit         busy    = 1'b0;   // an operation is in flight
    int         acc_cyc = 0;      // cycle in which it was accepted
    bit         m_idx   = 1'b0;   // its requester
    bit         m_prio  = INIT_PRIO[0];
    logic [3:0] pend_s;           // result of the in-flight op
    bit         pend_c, pend_o;
    logic [3:0] m_s     = 4'd0;   // last registered result
    bit         m_c     = 1'b0;
    bit         m_o     = 1'b0;
    bit         dut_grants[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected arithmetic from plain integers.
    task automatic model_op(input logic [3:0] a, input logic [3:0] b, input bit mode);
        int ia, ib, sa, sb, r, sr;
        ia = int'(a);
        ib = int'(b);
        r  = mode ? ia - ib : ia + ib;
        pend_s = 4'(r & 15);
        pend_c = mode ? (ia >= ib) : (r >= 16);
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        sr = mode ? sa - sb : sa + sb;
        pend_o = (sr > 7) || (sr < -8);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model.
    task automatic step(input bit r, input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                        input bit m0, input bit v1, input logic [3:0] a1, input logic [3:0] b1,
                        input bit m1, input bit k0, input bit k1);
        bit eg0, eg1, erv0, erv1;
        rst = r;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_mode = m0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_mode = m1;
        rsp0_ready = k0; rsp1_ready = k1;
        @(negedge clk);
        eg0  = !r && !busy && v0 && (!v1 || m_prio == 1'b0);
        eg1  = !r && !busy && v1 && (!v0 || m_prio == 1'b1);
        erv0 = busy && (cyc >= acc_cyc + 2) && (m_idx == 1'b0);
        erv1 = busy && (cyc >= acc_cyc + 2) && (m_idx == 1'b1);
        check("req0_ready", 8'(req0_ready), 8'(eg0));
        check("req1_ready", 8'(req1_ready), 8'(eg1));
        check("rsp0_valid", 8'(rsp0_valid), 8'(erv0));
        check("rsp1_valid", 8'(rsp1_valid), 8'(erv1));
        check("rsp_s", 8'(rsp_s), 8'(m_s));
        check("rsp_cout", 8'(rsp_cout), 8'(m_c));
`ifdef ADDSUB_OVF_FLAG_EN
        check("rsp_ovf", 8'(rsp_ovf), 8'(m_o));
`endif
        if (req0_ready === 1'b1) dut_grants.push_back(1'b0);
        if (req1_ready === 1'b1) dut_grants.push_back(1'b1);

        if (r) begin
            busy = 1'b0; m_prio = INIT_PRIO[0];
            m_s = 4'd0; m_c = 1'b0; m_o = 1'b0;
        end else if (busy) begin
            if (cyc == acc_cyc + 1) begin
                m_s = pend_s; m_c = pend_c; m_o = pend_o;
            end else if (cyc >= acc_cyc + 2 && (m_idx ? k1 : k0)) begin
                busy = 1'b0;
            end
        end else if (eg0 || eg1) begin
            busy = 1'b1; acc_cyc = cyc; m_idx = eg1; m_prio = !eg1;
            if (eg1) model_op(a1, b1, m1);
            else     model_op(a0, b0, m0);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic op0(input logic [3:0] a, input logic [3:0] b, input bit m);
        step(0, 1, a, b, m, 0, 4'd0, 4'd0, 0, 1, 1);
    endtask

    task automatic op1(input logic [3:0] a, input logic [3:0] b, input bit m);
        step(0, 0, 4'd0, 4'd0, 0, 1, a, b, m, 1, 1);
    endtask

    task automatic idle(input bit k0, input bit k1);
        step(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, k0, k1);
    endtask

    task automatic do_reset();
        step(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_mode = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_mode = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp0_valid", 8'(rsp0_valid), 8'd0);
        check("reset_rsp1_valid", 8'(rsp1_valid), 8'd0);
        check("reset_rsp_s", 8'(rsp_s), 8'd0);
        check("reset_rsp_cout", 8'(rsp_cout), 8'd0);
        do_reset();

        // Single add on requester 0.
        op0(4'd5, 4'd3, 1'b0);
        idle(1, 1);
        check("add_s", 8'(rsp_s), 8'd8);
        check("add_cout", 8'(rsp_cout), 8'd0);
        check("add_rsp1_valid", 8'(rsp1_valid), 8'd0);
        idle(1, 1);

        // Subtraction, both signs, on requester 1.
        op1(4'd5, 4'd3, 1'b1);
        idle(1, 1);
        check("sub_pos_s", 8'(rsp_s), 8'd2);
        check("sub_pos_cout", 8'(rsp_cout), 8'd1);
        idle(1, 1);
        op1(4'd3, 4'd5, 1'b1);
        idle(1, 1);
        check("sub_neg_s", 8'(rsp_s), 8'd14);
        check("sub_neg_cout", 8'(rsp_cout), 8'd0);
        idle(1, 1);

        // Contention from a fresh reset: grants must alternate 0,1,0,1.
        do_reset();
        dut_grants.delete();
        for (int i = 0; i < 12; i++)
            step(0, 1, 4'(i), 4'd1, 0, 1, 4'(i), 4'd2, 1, 1, 1);
        check("contention_count", 8'(dut_grants.size()), 8'd4);
        for (int i = 0; i < 4 && i < dut_grants.size(); i++)
            check("contention_grant", 8'(dut_grants[i]), 8'(i % 2));

        // Back-pressure: response held 5 cycles, no new accept meanwhile.
        idle(1, 1);
        op0(4'd9, 4'd4, 1'b0);
        idle(0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 1, 4'd1, 4'd1, 0, 1, 4'd2, 4'd2, 0, 0, 1);
        check("bp_rsp_s", 8'(rsp_s), 8'd13);
        step(0, 1, 4'd1, 4'd1, 0, 1, 4'd2, 4'd2, 0, 1, 1);
        step(0, 1, 4'd1, 4'd1, 0, 1, 4'd2, 4'd2, 0, 1, 1);
        idle(1, 1);
        idle(1, 1);
        idle(1, 1);

        // Reset while in EXEC abandons the op; request is re-accepted.
        op0(4'd6, 4'd6, 1'b0);
        step(1, 1, 4'd6, 4'd6, 0, 0, 4'd0, 4'd0, 0, 1, 1);
        check("rst_rsp0_valid", 8'(rsp0_valid), 8'd0);
        op0(4'd6, 4'd6, 1'b0);
        idle(1, 1);
        check("rst_reaccept_s", 8'(rsp_s), 8'd12);
        idle(1, 1);

`ifdef ADDSUB_OVF_FLAG_EN
        op0(4'd7, 4'd1, 1'b0);
        idle(1, 1);
        check("ovf_add_s", 8'(rsp_s), 8'd8);
        check("ovf_add_flag", 8'(rsp_ovf), 8'd1);
        idle(1, 1);
        op0(4'd8, 4'd1, 1'b1);
        idle(1, 1);
        check("ovf_sub_s", 8'(rsp_s), 8'd7);
        check("ovf_sub_flag", 8'(rsp_ovf), 8'd1);
        idle(1, 1);
        op0(4'd2, 4'd1, 1'b0);
        idle(1, 1);
        check("no_ovf_flag", 8'(rsp_ovf), 8'd0);
        idle(1, 1);
`endif

        // Randomized traffic with back-pressure and occasional reset.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
